// File: rtl/mvu_pe_acc_if.sv
// Stream bundle between the SIMD multiplier lanes, the accumulation stage and
// the downstream consumer of dot-product results.
//
// Handshake: a transfer occurs on a rising aclk edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer. Ready may depend combinationally on the consumer's state, never on
// the producer's valid.
interface mvu_pe_acc_if #(
   parameter int SIMD  = 4,
   parameter int TDstI = 8,
   parameter int TA    = 16
);
   logic                    in_v;
   logic                    in_rdy;
   logic [SIMD*TDstI-1:0]   in_prod;
   logic                    out_v;
   logic                    out_rdy;
   logic [TA-1:0]           out_acc;

   // Upstream product source / downstream result sink side
   modport master (
      output in_v, in_prod, out_rdy,
      input  in_rdy, out_v, out_acc
   );

   // Accumulation stage side
   modport slave (
      input  in_v, in_prod, out_rdy,
      output in_rdy, out_v, out_acc
   );
endinterface

// File: rtl/mvu_pe_acc.sv
// Per-PE accumulation stage: reduces each beat of SIMD products with an adder
// tree, accumulates SF fold beats and emits one result per output neuron.
// A held (unaccepted) result freezes the whole two-stage pipeline.
module mvu_pe_acc #(
   parameter int SIMD   = 4,
   parameter int TDstI  = 8,
   parameter int TA     = 16,
   parameter int SF     = 3,
   parameter int OP_SGN = 0
) (
   input  logic          aclk,
   input  logic          rst,
   mvu_pe_acc_if.slave   bus
);
   localparam int CW = (SF > 1) ? $clog2(SF) : 1;

   logic          en;
   logic          accept;
   logic [TA-1:0] lane_sum;
   logic          s1_v;
   logic [TA-1:0] s1_sum;
   logic [TA-1:0] acc;
   logic [TA-1:0] sum_next;
   logic [CW-1:0] sf_cnt;
   logic          last_beat;
   logic          out_v_q;
   logic [TA-1:0] out_acc_q;

   assign en         = !(out_v_q && !bus.out_rdy);
   assign accept     = bus.in_v && en;
   assign last_beat  = (sf_cnt == CW'(SF - 1));
   assign bus.in_rdy = en;
   assign bus.out_v  = out_v_q;
   assign bus.out_acc = out_acc_q;

   // Adder tree over the lanes, each lane widened to TA according to product signedness
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < SIMD; i++) begin
         if (OP_SGN == 0)
            lane_sum = lane_sum + TA'(bus.in_prod[i*TDstI +: TDstI]);
         else
            lane_sum = lane_sum + TA'($signed(bus.in_prod[i*TDstI +: TDstI]));
      end
   end

   // Running sum: the first fold beat restarts the accumulator
   always_comb begin
      sum_next = (sf_cnt == '0) ? s1_sum : acc + s1_sum;
   end

   // Stage 1: register the beat's lane sum
   always_ff @(posedge aclk) begin
      if (rst) begin
         s1_v   <= 1'b0;
         s1_sum <= '0;
      end else if (en) begin
         s1_v <= accept;
         if (accept)
            s1_sum <= lane_sum;
      end
   end

   // Stage 2: fold accumulation and result register; a new final sum overrides a drain
   always_ff @(posedge aclk) begin
      if (rst) begin
         acc       <= '0;
         sf_cnt    <= '0;
         out_v_q   <= 1'b0;
         out_acc_q <= '0;
      end else begin
         if (out_v_q && bus.out_rdy)
            out_v_q <= 1'b0;
         if (en && s1_v) begin
            acc <= sum_next;
            if (last_beat) begin
               out_acc_q <= sum_next;
               out_v_q   <= 1'b1;
               sf_cnt    <= '0;
            end else begin
               sf_cnt <= sf_cnt + CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_mvu_pe_acc.sv
// Bench for mvu_pe_acc: four instances cover unsigned/TA=16/SF=3, signed,
// narrow TA=10 wrap-around and SF=1. One instance is driven at a time; results
// from every instance are checked in order against a single expected queue
// whose entries carry the instance index above the result value.
module tb_mvu_pe_acc;
   localparam int W = 18;

   logic        aclk;
   logic        rst;
   logic        drv_v;
   logic [31:0] drv_prod;
   logic        drv_rdy;
   logic [1:0]  sel;
   logic        cur_rdy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];

   mvu_pe_acc_if #(.SIMD(4), .TDstI(8), .TA(16)) ifa ();
   mvu_pe_acc_if #(.SIMD(4), .TDstI(8), .TA(16)) ifb ();
   mvu_pe_acc_if #(.SIMD(4), .TDstI(8), .TA(10)) ifc ();
   mvu_pe_acc_if #(.SIMD(4), .TDstI(8), .TA(16)) ifd ();

   mvu_pe_acc #(.SIMD(4), .TDstI(8), .TA(16), .SF(3), .OP_SGN(0)) u_a (.aclk(aclk), .rst(rst), .bus(ifa.slave));
   mvu_pe_acc #(.SIMD(4), .TDstI(8), .TA(16), .SF(3), .OP_SGN(3)) u_b (.aclk(aclk), .rst(rst), .bus(ifb.slave));
   mvu_pe_acc #(.SIMD(4), .TDstI(8), .TA(10), .SF(3), .OP_SGN(0)) u_c (.aclk(aclk), .rst(rst), .bus(ifc.slave));
   mvu_pe_acc #(.SIMD(4), .TDstI(8), .TA(16), .SF(1), .OP_SGN(0)) u_d (.aclk(aclk), .rst(rst), .bus(ifd.slave));

   assign ifa.in_v    = drv_v && (sel == 2'd0);
   assign ifb.in_v    = drv_v && (sel == 2'd1);
   assign ifc.in_v    = drv_v && (sel == 2'd2);
   assign ifd.in_v    = drv_v && (sel == 2'd3);
   assign ifa.in_prod = drv_prod;
   assign ifb.in_prod = drv_prod;
   assign ifc.in_prod = drv_prod;
   assign ifd.in_prod = drv_prod;
   assign ifa.out_rdy = (sel == 2'd0) ? drv_rdy : 1'b1;
   assign ifb.out_rdy = (sel == 2'd1) ? drv_rdy : 1'b1;
   assign ifc.out_rdy = (sel == 2'd2) ? drv_rdy : 1'b1;
   assign ifd.out_rdy = (sel == 2'd3) ? drv_rdy : 1'b1;

   always_comb begin
      case (sel)
         2'd0:    cur_rdy = ifa.in_rdy;
         2'd1:    cur_rdy = ifb.in_rdy;
         2'd2:    cur_rdy = ifc.in_rdy;
         default: cur_rdy = ifd.in_rdy;
      endcase
   end

   // ---------------- clock ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic score(input logic [1:0] k, input logic [15:0] got);
      logic [W-1:0] e;
      n_tests++;
      assert (exp_q.size() > 0) else begin
         n_fail++;
         $error("FAIL sb_empty: observed=%0h from inst %0d expected=none", got, k);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_result", {14'd0, k, got}, {14'd0, e});
      end
   endtask

   // Result monitor: a transfer completes at the next rising edge
   always @(negedge aclk) begin
      if (!rst) begin
         if (ifa.out_v && ifa.out_rdy) score(2'd0, ifa.out_acc);
         if (ifb.out_v && ifb.out_rdy) score(2'd1, ifb.out_acc);
         if (ifc.out_v && ifc.out_rdy) score(2'd2, 16'(ifc.out_acc));
         if (ifd.out_v && ifd.out_rdy) score(2'd3, ifd.out_acc);
      end
   end

   // ---------------- model ----------------
   function automatic int beat_sum(input logic [31:0] p, input bit sgn);
      int s;
      logic [7:0] b;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         b = p[i*8 +: 8];
         s += sgn ? int'($signed(b)) : int'(b);
      end
      return s;
   endfunction

   function automatic logic [15:0] wrap(input int v, input int ta);
      return 16'(v & ((1 << ta) - 1));
   endfunction

   // ---------------- driver ----------------
   // Called between edges; returns one edge + 1 time unit after acceptance.
   task automatic send_beat(input logic [31:0] p);
      logic took;
      took = 1'b0;
      drv_v = 1'b1;
      drv_prod = p;
      for (int t = 0; t < 50; t++) begin
         #1;
         took = cur_rdy;
         @(posedge aclk);
         if (took) break;
      end
      #1;
      drv_v = 1'b0;
      check("beat_accept", {31'd0, took}, 32'd1);
   endtask

   task automatic idle(input int n);
      drv_v = 1'b0;
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
         @(posedge aclk);
         #1;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] pv [3];
      int tot;
      int gap_tbl [3][2];
      gap_tbl = '{'{0, 0}, '{3, 1}, '{2, 3}};

      rst = 1'b1; drv_v = 1'b0; drv_prod = '0; drv_rdy = 1'b1; sel = 2'd0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_out_v", {31'd0, ifa.out_v}, 32'd0);
      check("rst_out_acc", {16'd0, ifa.out_acc}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_rdy", {31'd0, ifa.in_rdy}, 32'd1);

      // Unsigned fold with latency check: 3 beats of 0x10 lanes -> 192
      exp_q.push_back({2'd0, 16'd192});
      send_beat(32'h10101010);
      send_beat(32'h10101010);
      drv_v = 1'b1; drv_prod = 32'h10101010;
      #1;
      check("lat_in_rdy", {31'd0, ifa.in_rdy}, 32'd1);
      @(posedge aclk);
      #1;
      drv_v = 1'b0;
      check("lat_edge_k", {31'd0, ifa.out_v}, 32'd0);
      @(posedge aclk);
      #1;
      check("lat_edge_k1", {31'd0, ifa.out_v}, 32'd1);
      check("lat_value", {16'd0, ifa.out_acc}, 32'd192);
      drain();

      // Backpressure: first result (60) held 5 cycles while in_v stays high
      drv_rdy = 1'b0;
      exp_q.push_back({2'd0, 16'd60});
      exp_q.push_back({2'd0, 16'd24});
      repeat (3) send_beat(32'h05050505);
      send_beat(32'h02020202);
      drv_v = 1'b1; drv_prod = 32'h02020202;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_in_rdy", {31'd0, ifa.in_rdy}, 32'd0);
         check("bp_out_v", {31'd0, ifa.out_v}, 32'd1);
         check("bp_out_acc", {16'd0, ifa.out_acc}, 32'd60);
         @(posedge aclk);
         #1;
      end
      drv_rdy = 1'b1;
      send_beat(32'h02020202);
      send_beat(32'h02020202);
      drain();

      // Random folds with random gaps
      for (int f = 0; f < 4; f++) begin
         tot = 0;
         for (int b = 0; b < 3; b++) begin
            pv[b] = $urandom;
            tot += beat_sum(pv[b], 1'b0);
         end
         exp_q.push_back({2'd0, wrap(tot, 16)});
         for (int b = 0; b < 3; b++) begin
            send_beat(pv[b]);
            idle($urandom_range(0, 2));
         end
      end
      drain();

      // Reset while a result is held and a beat sits in stage 1: all discarded
      drv_rdy = 1'b0;
      repeat (3) send_beat(32'h04040404);
      send_beat(32'h33333333);
      check("pre_rst_held", {31'd0, ifa.out_v}, 32'd1);
      rst = 1'b1;
      @(posedge aclk);
      @(posedge aclk);
      #1;
      rst = 1'b0;
      drv_rdy = 1'b1;
      #1;
      check("mid_rst_out_v", {31'd0, ifa.out_v}, 32'd0);
      check("mid_rst_out_acc", {16'd0, ifa.out_acc}, 32'd0);
      check("mid_rst_in_rdy", {31'd0, ifa.in_rdy}, 32'd1);
      idle(3);
      check("no_stale", {31'd0, ifa.out_v}, 32'd0);

      // Reset after 2 of 3 fold beats; the next full fold of 0x01 lanes gives 12
      send_beat(32'h09090909);
      send_beat(32'h09090909);
      rst = 1'b1;
      @(posedge aclk);
      @(posedge aclk);
      #1;
      rst = 1'b0;
      exp_q.push_back({2'd0, 16'd12});
      repeat (3) send_beat(32'h01010101);
      drain();

      // Signed products: all lanes -1 -> -12 ; lanes {7F,80,01,FF} -> -1 per beat
      sel = 2'd1;
      tot = 3 * beat_sum(32'hFFFFFFFF, 1'b1);
      exp_q.push_back({2'd1, wrap(tot, 16)});
      tot = 3 * beat_sum(32'hFF01807F, 1'b1);
      exp_q.push_back({2'd1, wrap(tot, 16)});
      repeat (3) send_beat(32'hFFFFFFFF);
      repeat (3) send_beat(32'hFF01807F);
      drain();
      check("sgn_const", {16'd0, ifb.out_acc}, 32'h0000FFFD);

      // TA=10 wrap-around with different gap patterns: 3060 mod 1024 = 1012
      sel = 2'd2;
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back({2'd2, wrap(3 * beat_sum(32'hFFFFFFFF, 1'b0), 10)});
         send_beat(32'hFFFFFFFF);
         idle(gap_tbl[f][0]);
         send_beat(32'hFFFFFFFF);
         idle(gap_tbl[f][1]);
         send_beat(32'hFFFFFFFF);
      end
      drain();
      check("wrap_const", {22'd0, ifc.out_acc}, 32'd1012);

      // SF=1: every beat is a result, one per cycle, in order
      sel = 2'd3;
      pv[0] = 32'h02020202; pv[1] = 32'h03030303; pv[2] = 32'h02020202;
      exp_q.push_back({2'd3, 16'd8});
      for (int b = 0; b < 3; b++)
         exp_q.push_back({2'd3, wrap(beat_sum(pv[b], 1'b0), 16)});
      send_beat(32'h02020202);
      for (int b = 0; b < 3; b++) begin
         send_beat(pv[b]);
         check("sf1_stream", {31'd0, ifd.out_v}, 32'd1);
      end
      @(posedge aclk);
      #1;
      check("sf1_last", {31'd0, ifd.out_v}, 32'd1);
      check("sf1_last_val", {16'd0, ifd.out_acc}, 32'd8);
      @(posedge aclk);
      #1;
      check("sf1_idle", {31'd0, ifd.out_v}, 32'd0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
